// File: rtl/bcd2_serial_subtractor.sv
// Two-digit packed-BCD subtractor, one decimal digit per clock.
// Result is ten's complement with borrow-out; start/done handshake for sequencing.
module bcd2_serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] minuend,
    input  logic [7:0] subtrahend,
    input  logic       Bin,
    output logic [7:0] difference,
    output logic       Bout,
    output logic       busy,
    output logic       done,
    output logic       invalid
);

    // state | meaning
    // IDLE  | waiting for start, outputs hold last result
    // D0    | units digit subtract
    // D1    | tens digit subtract, publish result and pulse done
    typedef enum logic [1:0] {IDLE, D0, D1} state_t;

    state_t     state;
    logic [7:0] m_q;
    logic [7:0] s_q;
    logic       borrow;
    logic [3:0] units;
    logic       inv_pend;
    logic [4:0] units_res;
    logic [4:0] tens_res;
    logic       nib_bad;

    // Returns {borrow_out, digit}; a negative partial result is folded back by +10.
    function automatic logic [4:0] digit_sub(input logic [3:0] a, input logic [3:0] b,
                                             input logic br);
        logic [4:0] t;
        t = {1'b0, a} - {1'b0, b} - {4'b0000, br};
        if (t[4])
            digit_sub = {1'b1, t[3:0] + 4'd10};
        else
            digit_sub = {1'b0, t[3:0]};
    endfunction

    assign units_res = digit_sub(m_q[3:0], s_q[3:0], borrow);
    assign tens_res  = digit_sub(m_q[7:4], s_q[7:4], borrow);
    assign nib_bad   = (minuend[3:0] > 4'd9) || (minuend[7:4] > 4'd9) ||
                       (subtrahend[3:0] > 4'd9) || (subtrahend[7:4] > 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m_q        <= 8'h00;
            s_q        <= 8'h00;
            borrow     <= 1'b0;
            units      <= 4'h0;
            inv_pend   <= 1'b0;
            difference <= 8'h00;
            Bout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q      <= minuend;
                        s_q      <= subtrahend;
                        borrow   <= Bin;
                        inv_pend <= nib_bad;
                        busy     <= 1'b1;
                        state    <= D0;
                    end
                end
                D0: begin
                    units  <= units_res[3:0];
                    borrow <= units_res[4];
                    state  <= D1;
                end
                D1: begin
                    if (inv_pend) begin
                        difference <= 8'h00;
                        Bout       <= 1'b0;
                        invalid    <= 1'b1;
                    end else begin
                        difference <= {tens_res[3:0], units};
                        Bout       <= tens_res[4];
                        invalid    <= 1'b0;
                    end
                    borrow <= tens_res[4];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2_serial_subtractor.sv
// Self-checking bench for bcd2_serial_subtractor: decimal model feeds a result queue,
// each scenario task pops and compares when done pulses.
module tb_bcd2_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       i;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] minuend = 8'h00;
    logic [7:0] subtrahend = 8'h00;
    logic       Bin = 1'b0;
    logic [7:0] difference;
    logic       Bout;
    logic       busy;
    logic       done;
    logic       invalid;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    bcd2_serial_subtractor dut (
        .clk(clk), .rst(rst), .start(start), .minuend(minuend), .subtrahend(subtrahend),
        .Bin(Bin), .difference(difference), .Bout(Bout), .busy(busy), .done(done),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] m, input logic [7:0] s, input logic bin);
        int   v;
        res_t r;
        if (m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9) begin
            r.d = 8'h00; r.b = 1'b0; r.i = 1'b1;
            return r;
        end
        v = int'(m[7:4]) * 10 + int'(m[3:0]) - int'(s[7:4]) * 10 - int'(s[3:0]) - int'(bin);
        r.b = (v < 0);
        if (v < 0) v = v + 100;
        r.d = {4'(v / 10), 4'(v % 10)};
        r.i = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Caller is at a negedge; start is seen by the next rising edge only.
    task automatic start_op(input logic [7:0] m, input logic [7:0] s, input logic bin);
        minuend = m; subtrahend = s; Bin = bin; start = 1'b1;
        exp_q.push_back(model(m, s, bin));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts negedges waited after start_op returned.
    task automatic collect(output res_t got, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = '{difference, Bout, invalid};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({difference, Bout, busy, done, invalid} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got diff=%h bout=%b busy=%b done=%b inv=%b, want all zero",
                     difference, Bout, busy, done, invalid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        res_t got, e;
        int   lat;
        start_op(8'h11, 8'h01, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got busy=%b, want 1", busy);
        end
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 2", lat);
        end
        checks++;
        if (got !== e || e.d !== 8'h10) begin
            errors++;
            $display("FAIL basic_result: got %h/%b/%b, want 10/0/0", got.d, got.b, got.i);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: got busy=%b with done, want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || difference !== 8'h10) begin
            errors++;
            $display("FAIL basic_pulse_hold: got done=%b diff=%h, want 0 10", done, difference);
        end
    endtask

    task automatic test_subtract_table;
        logic [16:0] tbl[6];
        res_t got, e;
        int   lat;
        tbl[0] = {8'h99, 8'h99, 1'b0};
        tbl[1] = {8'h00, 8'h00, 1'b1};
        tbl[2] = {8'h19, 8'h99, 1'b0};
        tbl[3] = {8'h50, 8'h01, 1'b0};
        tbl[4] = {8'h00, 8'h99, 1'b1};
        tbl[5] = {8'h45, 8'h23, 1'b1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start_op(tbl[k][16:9], tbl[k][8:1], tbl[k][0]);
            collect(got, lat);
            e = exp_q.pop_front();
            checks++;
            if (got !== e || lat != 2) begin
                errors++;
                $display("FAIL sub_%0d: %h-%h-%b got %h/%b/%b lat %0d, want %h/%b/%b lat 2",
                         k, tbl[k][16:9], tbl[k][8:1], tbl[k][0], got.d, got.b, got.i, lat,
                         e.d, e.b, e.i);
            end
        end
    endtask

    task automatic test_invalid;
        res_t got, e;
        int   lat;
        @(negedge clk);
        start_op(8'h1A, 8'h05, 1'b0);
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || got !== 10'b0000_0000_0_1) begin
            errors++;
            $display("FAIL invalid_min: got %h/%b/%b, want 00/0/1", got.d, got.b, got.i);
        end
        @(negedge clk);
        start_op(8'h05, 8'hA0, 1'b1);
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL invalid_sub: got %h/%b/%b, want %h/%b/%b", got.d, got.b, got.i, e.d, e.b, e.i);
        end
        @(negedge clk);
        start_op(8'h30, 8'h12, 1'b0);
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL invalid_clear: got %h/%b/%b, want %h/%b/%b", got.d, got.b, got.i, e.d, e.b, e.i);
        end
    endtask

    task automatic test_back_to_back;
        res_t got, e;
        int   lat;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            int a, b;
            a = $urandom_range(0, 99);
            b = $urandom_range(0, 99);
            start_op(to_bcd(a), to_bcd(b), 1'($urandom_range(0, 1)));
            collect(got, lat);
            e = exp_q.pop_front();
            checks++;
            if (got !== e || lat != 2) begin
                errors++;
                $display("FAIL b2b_%0d: %0d-%0d got %h/%b/%b lat %0d, want %h/%b/%b lat 2",
                         k, a, b, got.d, got.b, got.i, lat, e.d, e.b, e.i);
            end
        end
    endtask

    task automatic test_start_held;
        res_t got, e;
        int   ndone;
        @(negedge clk);
        minuend = 8'h42; subtrahend = 8'h17; Bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h42, 8'h17, 1'b0));
        exp_q.push_back(model(8'h08, 8'h09, 1'b1));
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                minuend = 8'h08; subtrahend = 8'h09; Bin = 1'b1;
            end
            if (c == 5) start = 1'b0;
            if (busy === 1'b1 && done === 1'b1) begin
                checks++; errors++;
                $display("FAIL held_busy_done: busy and done both high at cycle %0d", c);
            end
            if (done === 1'b1) begin
                ndone++;
                got = '{difference, Bout, invalid};
                e = exp_q.pop_front();
                checks++;
                if (got !== e || (c != 3 && c != 6)) begin
                    errors++;
                    $display("FAIL held_result_%0d: got %h/%b/%b at cycle %0d, want %h/%b/%b at 3 or 6",
                             ndone, got.d, got.b, got.i, c, e.d, e.b, e.i);
                end
            end
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL held_count: got %0d done pulses, want 2", ndone);
            exp_q.delete();
        end
    endtask

    task automatic test_ignore_busy;
        res_t got, e;
        int   lat, extra;
        @(negedge clk);
        start_op(8'h73, 8'h28, 1'b1);
        minuend = 8'h99; subtrahend = 8'h00; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        minuend = 8'h11; subtrahend = 8'h22;
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || lat != 1) begin
            errors++;
            $display("FAIL ignore_result: got %h/%b/%b lat %0d, want %h/%b/%b lat 1",
                     got.d, got.b, got.i, lat, e.d, e.b, e.i);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_queued: got %0d active cycles after done, want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        res_t got, e;
        int   lat, seen;
        @(negedge clk);
        start_op(8'h00, 8'h01, 1'b0);
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rmid_setup: got %h/%b/%b, want %h/%b/%b", got.d, got.b, got.i, e.d, e.b, e.i);
        end
        @(negedge clk);
        start_op(8'h55, 8'h22, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({difference, Bout, busy, done, invalid} !== 12'h000) begin
            errors++;
            $display("FAIL rmid_clear: got diff=%h bout=%b busy=%b done=%b inv=%b, want all zero",
                     difference, Bout, busy, done, invalid);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rmid_nodone: got %0d done pulses after abort, want 0", seen);
        end
        start_op(8'h64, 8'h08, 1'b0);
        collect(got, lat);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || lat != 2) begin
            errors++;
            $display("FAIL rmid_after: got %h/%b/%b lat %0d, want %h/%b/%b lat 2",
                     got.d, got.b, got.i, lat, e.d, e.b, e.i);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subtract_table();
        test_invalid();
        test_back_to_back();
        test_start_held();
        test_ignore_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
